nrisc_fetch_issue: RTL and testbench

- Instruction fetch and issue sequencer for the 8-bit nRisc core.
- Owns the PC and fetches 8-bit instructions from instruction memory through a valid handshake.
- Presents the 3-bit FuncCode to the registered control decoder, then samples the decoder's HALT and Branch outputs to choose the next PC.
- It is the producer side of the FuncCode/control interface: it drives FuncCode and consumes HALT/Branch.

---
 rtl/nrisc_fetch_issue.sv | 109 ++++++++++
 tb/tb_nrisc_fetch_issue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_fetch_issue.sv
// nRisc fetch/issue sequencer: owns the PC, fetches one 8-bit instruction at a time,
// issues its FuncCode to the registered control decoder, and uses the decoder's
// HALT/Branch outputs to choose the next PC.
//
// Handshakes:
//   imem_req/imem_valid : a fetch completes on a rising clock edge where imem_req=1
//                         and imem_valid=1. imem_valid is ignored when imem_req=0.
//   exec_done           : EXEC completes on a rising clock edge with exec_done=1,
//                         unless HALT=1, which wins and moves to HALTED.
//   resume              : a one-cycle pulse, honoured only while halted.
module nrisc_fetch_issue #(
  parameter int                    PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
  parameter int                    CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [7:0]           imem_data,
  input  logic                 imem_valid,
  output logic [2:0]           FuncCode,
  output logic [7:0]           instr,
  output logic                 instr_valid,
  input  logic                 HALT,
  input  logic                 Branch,
  input  logic                 branch_cond,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 exec_done,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [7:0]           r_instr;
  logic [2:0]           r_func;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Sequencer: state, PC, latched instruction and retired count.
  // HALT/Branch that are not a clean 1 fall through to the "not taken" path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 8'h00;
      r_func  <= 3'b111;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_instr <= imem_data;
            r_func  <= imem_data[7:5];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // decoder captures FuncCode on this edge
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (HALT) begin
            r_state <= S_HALTED;
          end else if (exec_done) begin
            if (Branch && branch_cond) begin
              r_pc <= branch_target;
            end else begin
              r_pc <= r_pc + PC_WIDTH'(1);
            end
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (resume) begin
            r_pc    <= r_pc + PC_WIDTH'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs: registers or pure decodes of the current state.
  always_comb begin
    imem_req    = (r_state == S_FETCH);
    imem_addr   = r_pc;
    pc          = r_pc;
    instr       = r_instr;
    FuncCode    = r_func;
    instr_valid = (r_state == S_ISSUE) || (r_state == S_EXEC);
    halted      = (r_state == S_HALTED);
    retired_cnt = r_cnt;
    dbg_state   = r_state;
  end

endmodule

// File: tb/tb_nrisc_fetch_issue.sv
// Bench for nrisc_fetch_issue: directed instruction sequences; a monitor checks every
// issued instruction against an expected queue, plus directed state checks.
module tb_nrisc_fetch_issue;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_data;
  logic        imem_valid;
  logic [2:0]  FuncCode;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        HALT;
  logic        Branch;
  logic        branch_cond;
  logic [7:0]  branch_target;
  logic        exec_done;
  logic        resume;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired_cnt;
  logic [1:0]  dbg_state;

  nrisc_fetch_issue dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .FuncCode(FuncCode), .instr(instr), .instr_valid(instr_valid),
    .HALT(HALT), .Branch(Branch), .branch_cond(branch_cond), .branch_target(branch_target),
    .exec_done(exec_done), .resume(resume),
    .pc(pc), .halted(halted), .retired_cnt(retired_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];   // {pc, instr, retired_cnt} expected at each issue
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;
  logic        prev_iv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // scoreboard monitor: pops one expectation on the first cycle of each issue
  always @(negedge clock) begin
    if (instr_valid === 1'b1 && prev_iv !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h expected none", {pc, instr, retired_cnt});
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({pc, instr, retired_cnt} !== e) begin
          errors++;
          $display("FAIL issue_record: got %0h expected %0h", {pc, instr, retired_cnt}, e);
        end
      end
    end
    prev_iv = instr_valid;
  end

  // driver: run one instruction starting at posedge+1 in FETCH
  task automatic do_instr(input logic [7:0] data, input int vdly, input int edly,
                          input logic br, input logic cond, input logic [7:0] tgt,
                          input logic hlt);
    logic [2:0] fc_before;
    fc_before = FuncCode;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    imem_data  = data;
    imem_valid = 1'b0;
    repeat (vdly) begin
      tick;
      chk("stall_pc", {24'd0, pc}, {24'd0, exp_pc});
      chk("stall_func", {29'd0, FuncCode}, {29'd0, fc_before});
      chk("stall_req", {31'd0, imem_req}, 32'd1);
    end
    exp_q.push_back({exp_pc, data, exp_cnt});
    imem_valid = 1'b1;
    tick;  // ISSUE
    imem_valid    = 1'b0;
    HALT          = hlt;
    Branch        = br;
    branch_cond   = cond;
    branch_target = tgt;
    chk("issue_req", {31'd0, imem_req}, 32'd0);
    chk("issue_func", {29'd0, FuncCode}, {29'd0, data[7:5]});
    tick;  // EXEC
    repeat (edly) begin
      chk("exec_func", {29'd0, FuncCode}, {29'd0, data[7:5]});
      chk("exec_pc", {24'd0, pc}, {24'd0, exp_pc});
      chk("exec_iv", {31'd0, instr_valid}, 32'd1);
      tick;
    end
    exec_done = 1'b1;
    tick;
    exec_done   = 1'b0;
    HALT        = 1'b0;
    Branch      = 1'b0;
    branch_cond = 1'b0;
    if (!hlt) begin
      exp_pc  = (br && cond) ? tgt : exp_pc + 8'd1;
      exp_cnt = exp_cnt + 16'd1;
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
      chk("retired", {16'd0, retired_cnt}, {16'd0, exp_cnt});
    end
  endtask

  task automatic check_halted(input logic [7:0] hpc);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_iv", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc", {24'd0, pc}, {24'd0, hpc});
    chk("halt_cnt", {16'd0, retired_cnt}, {16'd0, exp_cnt});
  endtask

  task automatic do_resume;
    resume = 1'b1;
    tick;
    resume = 1'b0;
    exp_pc = exp_pc + 8'd1;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
  endtask

  initial begin
    reset_n = 1'b0; imem_data = 8'h00; imem_valid = 1'b0;
    HALT = 1'b0; Branch = 1'b0; branch_cond = 1'b0; branch_target = 8'h00;
    exec_done = 1'b0; resume = 1'b0;
    exp_pc = 8'h00; exp_cnt = 16'd0;
    repeat (2) tick;
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_instr", {24'd0, instr}, 32'h0);
    chk("rst_func", {29'd0, FuncCode}, 32'h7);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
    reset_n = 1'b1;
    tick;

    // three straight-line instructions, minimum latency
    do_instr(8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(8'h20, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(8'h40, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("seq_pc", {24'd0, pc}, 32'h3);
    chk("seq_cnt", {16'd0, retired_cnt}, 32'd3);

    // branch taken at pc=4, then not taken at pc=4
    do_instr(8'h00, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_instr(8'hA0, 0, 0, 1'b1, 1'b1, 8'h10, 1'b0);
    chk("br_taken_addr", {24'd0, imem_addr}, 32'h10);
    do_instr(8'hA0, 0, 0, 1'b1, 1'b1, 8'h04, 1'b0);
    do_instr(8'hA0, 0, 0, 1'b1, 1'b0, 8'h10, 1'b0);
    chk("br_nottaken_addr", {24'd0, imem_addr}, 32'h5);

    // halt at pc=9, resume to 10
    do_instr(8'hA0, 0, 0, 1'b1, 1'b1, 8'h09, 1'b0);
    do_instr(8'hE0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_halted(8'h09);
    repeat (3) tick;
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_func", {29'd0, FuncCode}, 32'h7);
    do_resume;

    // stalls on both handshakes; resume held high must be ignored
    resume = 1'b1;
    do_instr(8'h60, 5, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    resume = 1'b0;
    chk("stall_done_pc", {24'd0, pc}, 32'hB);

    // pc wrap from FF to 00
    do_instr(8'hA0, 0, 0, 1'b1, 1'b1, 8'hFF, 1'b0);
    do_instr(8'h20, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("wrap_pc", {24'd0, pc}, 32'h0);

    // HALT and Branch together: halt wins, no branch
    do_instr(8'hE0, 0, 0, 1'b1, 1'b1, 8'h55, 1'b1);
    check_halted(8'h00);
    do_resume;

    // asynchronous reset in EXEC with a branch pending
    exp_q.push_back({exp_pc, 8'hA0, exp_cnt});
    imem_data = 8'hA0; imem_valid = 1'b1;
    tick;
    imem_valid = 1'b0; Branch = 1'b1; branch_cond = 1'b1; branch_target = 8'h33;
    tick;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", {24'd0, pc}, 32'h0);
    chk("arst_iv", {31'd0, instr_valid}, 32'd0);
    chk("arst_cnt", {16'd0, retired_cnt}, 32'd0);
    chk("arst_func", {29'd0, FuncCode}, 32'h7);
    Branch = 1'b0; branch_cond = 1'b0;
    exp_pc = 8'h00; exp_cnt = 16'd0;
    tick;
    reset_n = 1'b1;
    tick;
    chk("arst_req", {31'd0, imem_req}, 32'd1);
    chk("arst_addr", {24'd0, imem_addr}, 32'h0);
    do_instr(8'h20, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

    repeat (2) tick;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
